fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, sitting directly upstream of the instruction memory and feeding the decode stage.
- Holds the program counter and drives the word address into the instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Applies stalls from the hazard unit and branch/jump redirects resolved in ID.
- The instruction memory read is combinational within the same cycle; this block provides all sequencing.

---
 rtl/fetch_stage_pkg.sv | 38 +++
 rtl/fetch_stage_ifid_reg.sv | 29 ++
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// The IF/ID bundle is a packed struct so it moves as one register word.
package fetch_stage_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int JIDX_W = 26;
   localparam int IFID_W = DATA_W * 2 + 1;

   localparam logic [DATA_W-1:0] RESET_PC  = 32'h0000_0000;
   localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [DATA_W-1:0] PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      IFID_HOLD   = 2'd0,
      IFID_LOAD   = 2'd1,
      IFID_BUBBLE = 2'd2
   } ifid_ctrl_e;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] pc_plus4;
      logic              valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE_VAL = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

   // J-format target keeps the region bits of the jump's own PC+4.
   function automatic logic [DATA_W-1:0] jump_target(input logic [DATA_W-1:0] pc4,
                                                     input logic [JIDX_W-1:0] idx);
      return {pc4[DATA_W-1:DATA_W-4], idx, 2'b00};
   endfunction

   function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
      return addr & ~(DATA_W'(3));
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or replace it
// with a bubble. Reset leaves it in the bubble state.
module ifid_reg
   import fetch_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  ifid_ctrl_e ctrl,
   input  ifid_t      d,
   output ifid_t      q
);

   logic [IFID_W-1:0] q_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= IFID_BUBBLE_VAL;
      end else begin
         case (ctrl)
            IFID_LOAD:   q_r <= d;
            IFID_BUBBLE: q_r <= IFID_BUBBLE_VAL;
            default:     q_r <= q_r;
         endcase
      end
   end

   assign q = ifid_t'(q_r);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID capture and
// delivered-instruction counter. Instruction memory is read combinationally.
module fetch_stage
   import fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_ins,
   input  logic              stall,
   input  logic              flush,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   input  logic              jump,
   input  logic [JIDX_W-1:0] jump_index,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] id_instr,
   output logic [DATA_W-1:0] id_pc_plus4,
   output logic              id_valid,
   output logic [31:0]       fetch_count
);

   logic [DATA_W-1:0] pc_plus4;
   logic [DATA_W-1:0] pc_next;
   ifid_ctrl_e        ifid_ctrl;
   ifid_t             ifid_d;
   ifid_t             ifid_q;
   logic              count_en;

   assign pc_plus4  = pc + PC_STEP;
   assign imem_addr = pc[ADDR_W+1:2];

   // Redirects win over hazards: the wrong-path fetch is always discarded.
   always_comb begin
      pc_next   = pc_plus4;
      ifid_ctrl = IFID_LOAD;
      count_en  = 1'b0;
      if (branch_taken) begin
         pc_next   = word_align(branch_target);
         ifid_ctrl = IFID_BUBBLE;
      end else if (jump) begin
         pc_next   = jump_target(ifid_q.pc_plus4, jump_index);
         ifid_ctrl = IFID_BUBBLE;
      end else if (stall) begin
         pc_next   = pc;
         ifid_ctrl = IFID_HOLD;
      end else if (flush) begin
         ifid_ctrl = IFID_BUBBLE;
      end else begin
         count_en  = 1'b1;
      end
   end

   assign ifid_d = '{instr: imem_ins, pc_plus4: pc_plus4, valid: 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         fetch_count <= '0;
      end else begin
         pc <= pc_next;
         if (count_en) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

   ifid_reg u_ifid (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (ifid_ctrl),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign id_instr    = ifid_q.instr;
   assign id_pc_plus4 = ifid_q.pc_plus4;
   assign id_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes per-cycle expectations,
// a monitor pops and compares them one tick after each rising edge.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [4:0]  imem_addr;
   logic [31:0] imem_ins;
   logic        stall, flush, branch_taken, jump;
   logic [31:0] branch_target;
   logic [25:0] jump_index;
   logic [31:0] pc, id_instr, id_pc_plus4, fetch_count;
   logic        id_valid;

   logic [31:0] mem [32];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int step_no = 0;

   typedef struct {
      int          cyc;
      int          id;
      logic [31:0] pc;
      logic [4:0]  addr;
      logic [31:0] instr;
      logic [31:0] p4;
      logic        v;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_ins      (imem_ins),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_index    (jump_index),
      .pc            (pc),
      .id_instr      (id_instr),
      .id_pc_plus4   (id_pc_plus4),
      .id_valid      (id_valid),
      .fetch_count   (fetch_count)
   );

   assign imem_ins = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: compares every expectation due on this edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk($sformatf("step%0d_pc", e.id),          pc,          e.pc);
            chk($sformatf("step%0d_imem_addr", e.id),   {27'd0, imem_addr}, {27'd0, e.addr});
            chk($sformatf("step%0d_id_instr", e.id),    id_instr,    e.instr);
            chk($sformatf("step%0d_id_pc_plus4", e.id), id_pc_plus4, e.p4);
            chk($sformatf("step%0d_id_valid", e.id),    {31'd0, id_valid}, {31'd0, e.v});
            chk($sformatf("step%0d_fetch_count", e.id), fetch_count, e.cnt);
         end
      end
   end

   // Drive one cycle of inputs and queue the state expected after the next edge.
   task automatic step(input logic st, input logic fl, input logic br, input logic jp,
                       input logic [31:0] bt, input logic [25:0] ji,
                       input logic [31:0] epc, input logic [31:0] ein,
                       input logic [31:0] ep4, input logic ev, input logic [31:0] ecnt);
      exp_t e;
      stall = st; flush = fl; branch_taken = br; jump = jp;
      branch_target = bt; jump_index = ji;
      step_no++;
      e.cyc = cyc + 1; e.id = step_no; e.pc = epc; e.addr = epc[6:2];
      e.instr = ein; e.p4 = ep4; e.v = ev; e.cnt = ecnt;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #20000;
      errors++;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      rst_n = 1'b0;
      stall = 0; flush = 0; branch_taken = 0; jump = 0;
      branch_target = '0; jump_index = '0;

      #12;
      chk("reset_pc",          pc,          32'h0);
      chk("reset_id_instr",    id_instr,    32'h0);
      chk("reset_id_pc_plus4", id_pc_plus4, 32'h0);
      chk("reset_id_valid",    {31'd0, id_valid}, 32'h0);
      chk("reset_fetch_count", fetch_count, 32'h0);
      chk("reset_imem_addr",   {27'd0, imem_addr}, 32'h0);

      @(posedge clk); #2;
      rst_n = 1'b1;

      //   st fl br jp bt            ji           pc            instr         p4            v  cnt
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h4,        32'h11,       32'h4,        1, 1);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h8,        32'h22,       32'h8,        1, 2);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'hC,        32'h33,       32'hC,        1, 3);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h10,       32'h44,       32'h10,       1, 4);
      // misaligned branch target with stall and flush also asserted
      step(1, 1, 1, 0, 32'h41,       26'h0,       32'h40,       32'h0,        32'h0,        0, 4);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h44,       32'hA000_0010, 32'h44,      1, 5);
      step(0, 0, 1, 0, 32'hC,        26'h0,       32'hC,        32'h0,        32'h0,        0, 5);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h10,       32'h44,       32'h10,       1, 6);
      step(0, 0, 0, 1, 32'h0,        26'h5,       32'h14,       32'h0,        32'h0,        0, 6);
      step(0, 0, 1, 1, 32'h20,       26'h5,       32'h20,       32'h0,        32'h0,        0, 6);
      step(0, 0, 1, 0, 32'h0,        26'h0,       32'h0,        32'h0,        32'h0,        0, 6);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h4,        32'h11,       32'h4,        1, 7);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h8,        32'h22,       32'h8,        1, 8);
      step(1, 0, 0, 0, 32'h0,        26'h0,       32'h8,        32'h22,       32'h8,        1, 8);
      step(1, 0, 0, 0, 32'h0,        26'h0,       32'h8,        32'h22,       32'h8,        1, 8);
      step(1, 0, 0, 0, 32'h0,        26'h0,       32'h8,        32'h22,       32'h8,        1, 8);
      step(1, 1, 0, 0, 32'h0,        26'h0,       32'h8,        32'h22,       32'h8,        1, 8);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'hC,        32'h33,       32'hC,        1, 9);
      step(0, 1, 0, 0, 32'h0,        26'h0,       32'h10,       32'h0,        32'h0,        0, 9);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h14,       32'hA000_0004, 32'h14,      1, 10);
      // region bits of the jump come from id_pc_plus4; pc+4 wraps to zero
      step(0, 0, 1, 0, 32'hF000_0000, 26'h0,      32'hF000_0000, 32'h0,       32'h0,        0, 10);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'hF000_0004, 32'h11,      32'hF000_0004, 1, 11);
      step(0, 0, 0, 1, 32'h0,        26'h3FF_FFFF, 32'hFFFF_FFFC, 32'h0,      32'h0,        0, 11);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h0,        32'hA000_001F, 32'h0,       1, 12);
      // imem address wraps from 31 to 0 as pc crosses 0x80
      step(0, 0, 1, 0, 32'h78,       26'h0,       32'h78,       32'h0,        32'h0,        0, 12);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h7C,       32'hA000_001E, 32'h7C,      1, 13);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h80,       32'hA000_001F, 32'h80,      1, 14);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h84,       32'h11,       32'h84,       1, 15);

      // asynchronous reset in the middle of a stalled cycle
      stall = 1'b1;
      #4;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc",          pc,          32'h0);
      chk("async_rst_id_instr",    id_instr,    32'h0);
      chk("async_rst_id_pc_plus4", id_pc_plus4, 32'h0);
      chk("async_rst_id_valid",    {31'd0, id_valid}, 32'h0);
      chk("async_rst_fetch_count", fetch_count, 32'h0);
      @(posedge clk); #2;
      stall = 1'b0;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h4,        32'h11,       32'h4,        1, 1);
      step(0, 0, 0, 0, 32'h0,        26'h0,       32'h8,        32'h22,       32'h8,        1, 2);

      @(posedge clk); #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
